iob_fifo_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the asynchronous FIFO read port, in the read clock domain. It turns the FIFO's enable/empty interface, which has a one-cycle registered read latency, into a valid/ready stream with a 2-entry prefetch buffer. The stream sustains one word per cycle and never drops or duplicates a word under backpressure. It also keeps a wrap-around count of delivered words.

---
 rtl/iob_fifo_rd_stream_if.sv | 44 ++++
 rtl/iob_fifo_rd_stream.sv | 88 ++++++++
 tb/tb_iob_fifo_rd_stream.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/iob_fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : iob_fifo_rd_stream_if
// Description : Bundles the FIFO read-port signals and the outgoing
//               valid/ready stream of the iob_fifo_rd_stream adapter.
//               master : adapter side (drives fifo_r_en and the stream)
//               slave  : FIFO + stream consumer side
//               Signals: fifo_r_en, fifo_r_data, fifo_r_empty,
//                        m_valid, m_ready, m_data, xfer_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface iob_fifo_rd_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) ();
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_r_data;
    logic              fifo_r_empty;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (
        output fifo_r_en,
        input  fifo_r_data,
        input  fifo_r_empty,
        output m_valid,
        input  m_ready,
        output m_data,
        output xfer_cnt
    );

    modport slave (
        input  fifo_r_en,
        output fifo_r_data,
        output fifo_r_empty,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/iob_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : iob_fifo_rd_stream
// Description : Read-side adapter for the async FIFO read port. Converts the
//               enable/empty interface (one-cycle registered read latency)
//               into a valid/ready stream using a 2-entry prefetch buffer,
//               and counts accepted handshakes (wrapping).
//               Ports:
//                 clk  - read-domain clock (same as FIFO r_clk)
//                 rst  - asynchronous, active-low reset
//                 bus  - iob_fifo_rd_stream_if.master (FIFO read port,
//                        stream output, delivered-word counter)
// Revision    : 1.0 - initial release
// ============================================================================
module iob_fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    iob_fifo_rd_stream_if.master    bus
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;
    localparam logic [2:0] c_LEVEL_LIM = 3'd2;

    logic [1:0]        r_occ;       // words held in the buffer (0..2)
    logic              r_inflight;  // read issued last cycle, data lands now
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_xfer_cnt;

    logic              w_pop;
    logic [2:0]        w_level;
    logic [1:0]        w_occ_after_pop;
    logic              w_r_en;

    assign w_pop = (r_occ != c_OCC_EMPTY) & bus.m_ready;

    // Occupancy the buffer will have next cycle, counting the word that is
    // arriving now. A new read is only issued if its data will still fit,
    // so occupancy can never exceed two.
    assign w_level         = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};

    // Gated by rst so no read is launched while reset is held.
    assign w_r_en = rst & ~bus.fifo_r_empty & (w_level < c_LEVEL_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ      <= c_OCC_EMPTY;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_inflight <= w_r_en;
            r_occ      <= w_level[1:0];

            // Popping a full buffer promotes the tail word to the head.
            if (w_pop && (r_occ == c_OCC_FULL)) begin
                r_head <= r_tail;
            end

            // Arriving word goes to whichever slot is next free once this
            // cycle's pop is accounted for.
            if (r_inflight) begin
                if (w_occ_after_pop == c_OCC_EMPTY) begin
                    r_head <= bus.fifo_r_data;
                end else begin
                    r_tail <= bus.fifo_r_data;
                end
            end

            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.fifo_r_en = w_r_en;
    assign bus.m_valid   = (r_occ != c_OCC_EMPTY);
    assign bus.m_data    = r_head;
    assign bus.xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iob_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_fifo_rd_stream
// Description : Directed self-checking bench for iob_fifo_rd_stream. A small
//               FIFO read-port model (one-cycle read latency) feeds the DUT;
//               a negedge monitor collects delivered words and checks the
//               empty-gating, occupancy and stall-hold rules every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_fifo_rd_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iob_fifo_rd_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) fif ();

    iob_fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    // ---------------- FIFO read-port model ----------------
    logic [7:0] q[$];
    int         rd_idx      = 0;
    int         wr_cnt      = 0;
    logic       force_empty = 1'b0;
    logic [7:0] fdata       = 8'h00;

    assign fif.fifo_r_empty = (rd_idx == wr_cnt) | force_empty;
    assign fif.fifo_r_data  = fdata;

    always @(posedge clk) begin
        if (fif.fifo_r_en) begin
            fdata  <= q[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    task automatic push(input logic [7:0] v);
        q.push_back(v);
        wr_cnt = wr_cnt + 1;
    endtask

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] got[$];
    int         pop_cyc[$];
    int         cyc        = 0;
    int         ren_cnt    = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            chk("ren_while_empty", {31'd0, fif.fifo_r_en & fif.fifo_r_empty}, 32'd0);
            chk("occ_le_2", {31'd0, (dut.r_occ <= 2'd2)}, 32'd1);
            if (prev_stall) begin
                chk("hold_valid", {31'd0, fif.m_valid}, 32'd1);
                chk("hold_data", {24'd0, fif.m_data}, {24'd0, prev_data});
            end
            if (fif.fifo_r_en) ren_cnt = ren_cnt + 1;
            if (fif.m_valid && fif.m_ready) begin
                got.push_back(fif.m_data);
                pop_cyc.push_back(cyc);
            end
            prev_stall = fif.m_valid & ~fif.m_ready;
            prev_data  = fif.m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            if (tag == "bp_rand") fif.m_ready = 1'($urandom_range(0, 1));
            go(1);
            k++;
        end
        chk({tag, "_count"}, got.size(), n);
    endtask

    task automatic check_order(input string tag, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk($sformatf("%s_w%0d", tag, i), {24'd0, got[i]}, {24'd0, base + 8'(i)});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int ren0;
        fif.m_ready = 1'b1;
        push(8'hA5);

        // Reset held with FIFO non-empty: everything quiet.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ren", {31'd0, fif.fifo_r_en}, 32'd0);
            chk("rst_valid", {31'd0, fif.m_valid}, 32'd0);
            chk("rst_data", {24'd0, fif.m_data}, 32'd0);
            chk("rst_cnt", {28'd0, fif.xfer_cnt}, 32'd0);
        end

        // Release, then single-word latency.
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("single_ren_c0", {31'd0, fif.fifo_r_en}, 32'd1);
        chk("single_valid_c0", {31'd0, fif.m_valid}, 32'd0);
        @(negedge clk);
        chk("single_ren_c1", {31'd0, fif.fifo_r_en}, 32'd0);
        chk("single_valid_c1", {31'd0, fif.m_valid}, 32'd0);
        @(negedge clk);
        chk("single_valid_c2", {31'd0, fif.m_valid}, 32'd1);
        chk("single_data_c2", {24'd0, fif.m_data}, 32'hA5);
        @(negedge clk);
        chk("single_valid_c3", {31'd0, fif.m_valid}, 32'd0);
        chk("single_cnt", {28'd0, fif.xfer_cnt}, 32'd1);
        chk("single_ren_pulses", ren_cnt, 1);
        go(1);

        // Streaming 16 words back to back.
        clear_log();
        for (int i = 0; i < 16; i++) push(8'(i));
        wait_pops(16, 60, "stream");
        check_order("stream", 8'h00, 16);
        if (pop_cyc.size() == 16) chk("stream_gap", pop_cyc[15] - pop_cyc[0], 15);
        chk("stream_cnt", {28'd0, fif.xfer_cnt}, 32'd1);   // 17 mod 16

        // Backpressure from start-up.
        go(3);
        clear_log();
        fif.m_ready = 1'b0;
        ren0 = ren_cnt;
        for (int i = 0; i < 8; i++) push(8'(i));
        go(10);
        chk("bp_ren_pulses", ren_cnt - ren0, 2);
        chk("bp_valid", {31'd0, fif.m_valid}, 32'd1);
        chk("bp_data", {24'd0, fif.m_data}, 32'h00);
        fif.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_ren_same_cycle", {31'd0, fif.fifo_r_en}, 32'd1);
        go(1);
        wait_pops(8, 400, "bp_rand");
        check_order("bp", 8'h00, 8);
        fif.m_ready = 1'b1;
        go(3);
        chk("bp_no_extra", got.size(), 8);
        chk("bp_cnt", {28'd0, fif.xfer_cnt}, 32'd9);      // 25 mod 16

        // Empty mid-stream.
        clear_log();
        for (int i = 0; i < 3; i++) push(8'h10 + 8'(i));
        wait_pops(3, 30, "emp_a");
        force_empty = 1'b1;
        for (int i = 3; i < 6; i++) push(8'h10 + 8'(i));
        go(5);
        chk("emp_hold_count", got.size(), 3);
        chk("emp_hold_valid", {31'd0, fif.m_valid}, 32'd0);
        force_empty = 1'b0;
        wait_pops(6, 30, "emp_b");
        check_order("emp", 8'h10, 6);
        chk("emp_cnt", {28'd0, fif.xfer_cnt}, 32'd15);    // 31 mod 16

        // Counter wrap 15 -> 0, then 17 more words -> 1.
        clear_log();
        push(8'h20);
        wait_pops(1, 20, "wrap_a");
        chk("wrap_zero", {28'd0, fif.xfer_cnt}, 32'd0);
        clear_log();
        for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
        wait_pops(17, 60, "wrap_b");
        check_order("wrap", 8'h30, 17);
        chk("wrap_one", {28'd0, fif.xfer_cnt}, 32'd1);

        // Asynchronous reset with a full buffer.
        go(2);
        clear_log();
        fif.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        go(6);
        chk("rstmid_occ", {30'd0, dut.r_occ}, 32'd2);
        chk("rstmid_valid_pre", {31'd0, fif.m_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_valid", {31'd0, fif.m_valid}, 32'd0);
        chk("rstmid_cnt", {28'd0, fif.xfer_cnt}, 32'd0);
        chk("rstmid_ren", {31'd0, fif.fifo_r_en}, 32'd0);
        chk("rstmid_data", {24'd0, fif.m_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        fif.m_ready = 1'b1;
        wait_pops(2, 20, "rstmid");
        go(5);
        chk("rstmid_no_stale", got.size(), 2);
        check_order("rstmid", 8'h42, 2);
        chk("rstmid_cnt_after", {28'd0, fif.xfer_cnt}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
